// File: rtl/cla_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor.
//  - FSM state encoding (2'd3 is unused and decodes to IDLE)
//  - digit width (bits processed per cycle)
//  - width helpers for the digit counter
package cla_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DIGIT_W = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Digit counter width for a given operand width, never below one bit.
   function automatic int cnt_width(input int width);
      int r;
      r = clog2(width / DIGIT_W);
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cla_serial_subtractor_bla_sub2.sv
// bla_sub2: combinational 2-bit borrow-lookahead subtractor.
//  a[1:0], b[1:0] : minuend / subtrahend digit
//  bin            : borrow into bit 0
//  d[1:0]         : a - b - bin (mod 4)
//  bout           : borrow out of bit 1
module bla_sub2
   import cla_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               bin,
   output logic [DIGIT_W-1:0] d,
   output logic               bout
);

   logic [1:0] p_s;
   logic [1:0] g_s;
   logic [2:0] bw_s;

   // Propagate when bits are equal, generate when a=0,b=1; borrows resolved by lookahead.
   always_comb begin
      p_s     = ~(a ^ b);
      g_s     = ~a & b;
      bw_s[0] = bin;
      bw_s[1] = g_s[0] | (p_s[0] & bin);
      bw_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
      d       = a ^ b ^ bw_s[1:0];
      bout    = bw_s[2];
   end

endmodule

// File: rtl/cla_serial_subtractor.sv
// cla_serial_subtractor: digit-serial subtractor, Diff = A - B - Borrow_in,
// two bits per cycle over WIDTH/2 cycles, valid/ready on both sides.
//  clk, rst                  : clock, synchronous active-high reset
//  in_valid/in_ready         : operand handshake (in_ready high only in IDLE)
//  A, B, Borrow_in           : operands, latched on the accept edge
//  out_valid/out_ready       : result handshake (out_valid high only in DONE)
//  Diff, Borrow_out, Overflow: result, held stable until the next run writes it
module cla_serial_subtractor
   import cla_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow_out,
   output logic             Overflow
);

   localparam int N     = WIDTH / DIGIT_W;
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("cla_serial_subtractor: WIDTH must be even and >= 2");
   end

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               borrow_q, borrow_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;

   logic [CNT_W:0]       base_s;
   logic [DIGIT_W-1:0]   dig_a_s;
   logic [DIGIT_W-1:0]   dig_b_s;
   logic [DIGIT_W-1:0]   dig_d_s;
   logic                 dig_bout_s;

   // Bit offset of the current digit: the counter selects bits [2k+1:2k].
   always_comb begin
      base_s  = {cnt_q, 1'b0};
      dig_a_s = a_q[base_s +: DIGIT_W];
      dig_b_s = b_q[base_s +: DIGIT_W];
   end

   bla_sub2 u_digit (
      .a    (dig_a_s),
      .b    (dig_b_s),
      .bin  (borrow_q),
      .d    (dig_d_s),
      .bout (dig_bout_s)
   );

   // Next-state logic: FSM, digit counter, operand and result registers.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      borrow_d = borrow_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_RUN: begin
            diff_d[base_s +: DIGIT_W] = dig_d_s;
            borrow_d                  = dig_bout_s;
            if (cnt_q == LAST_DIGIT) begin
               // Last digit carries the result MSB, so the flags settle here.
               bout_d  = dig_bout_s;
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (dig_d_s[1] ^ a_q[WIDTH-1]);
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1'b1);
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            // IDLE and the unused encoding both behave as IDLE.
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Borrow_in;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready   = (state_q != ST_RUN) && (state_q != ST_DONE);
   assign out_valid  = (state_q == ST_DONE);
   assign Diff       = diff_q;
   assign Borrow_out = bout_q;
   assign Overflow   = ovf_q;

endmodule

// File: tb/tb_cla_serial_subtractor.sv
module tb_cla_serial_subtractor;

   logic       clk;
   logic       rst;

   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, diff;
   logic       bin, bout, ovf;

   logic       in_valid2, in_ready2, out_valid2, out_ready2;
   logic [1:0] a2, b2, diff2;
   logic       bin2, bout2, ovf2;

   int checks;
   int failures;

   cla_serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Borrow_in(bin),
      .out_valid(out_valid), .out_ready(out_ready),
      .Diff(diff), .Borrow_out(bout), .Overflow(ovf)
   );

   cla_serial_subtractor #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .A(a2), .B(b2), .Borrow_in(bin2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .Diff(diff2), .Borrow_out(bout2), .Overflow(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation: optional input gap, optional in_valid pokes during RUN,
   // out_ready held low for gout cycles in DONE.
   task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input int gin, input int gout,
                          input logic [7:0] ed, input logic eb, input logic eo, input bit poke);
      int n;
      repeat (gin) begin @(posedge clk); #1; end
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      a = ~ta; b = ~tb_; bin = ~tbin;
      if (!poke) in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1; n++;
         if (poke) check_eq("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      check_eq("latency8", n, 32'd4);
      check_eq("diff8", {24'd0, diff}, {24'd0, ed});
      check_eq("borrow8", {31'd0, bout}, {31'd0, eb});
      check_eq("ovf8", {31'd0, ovf}, {31'd0, eo});
      repeat (gout) begin
         @(posedge clk); #1;
         check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
         check_eq("hold_diff", {24'd0, diff}, {24'd0, ed});
         check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
      check_eq("valid_after_hs", {31'd0, out_valid}, 32'd0);
      check_eq("diff_after_hs", {24'd0, diff}, {24'd0, ed});
   endtask

   // One WIDTH=2 operation checked against the arithmetic model.
   task automatic run_op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tbin);
      logic [2:0] r;
      logic       eo;
      int         n;
      r  = {1'b0, ta} - {1'b0, tb_} - {2'b00, tbin};
      eo = (ta[1] ^ tb_[1]) & (r[1] ^ ta[1]);
      a2 = ta; b2 = tb_; bin2 = tbin; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 10) begin @(posedge clk); #1; n++; end
      check_eq("latency2", n, 32'd1);
      check_eq("diff2", {30'd0, diff2}, {30'd0, r[1:0]});
      check_eq("borrow2", {31'd0, bout2}, {31'd0, r[2]});
      check_eq("ovf2", {31'd0, ovf2}, {31'd0, eo});
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      check_eq("in_ready2_after_hs", {31'd0, in_ready2}, 32'd1);
   endtask

   initial begin
      logic [7:0] ra, rb, ed;
      logic       rbin, eo;
      logic [8:0] r;
      int         n;

      checks = 0; failures = 0;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = 2'b00; b2 = 2'b00; bin2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_diff", {24'd0, diff}, 32'd0);
      check_eq("rst_borrow", {31'd0, bout}, 32'd0);
      check_eq("rst_ovf", {31'd0, ovf}, 32'd0);

      // Directed vectors with hand-computed results.
      run_op8(8'h5A, 8'h3C, 1'b0, 0, 0, 8'h1E, 1'b0, 1'b0, 1'b0);
      run_op8(8'h00, 8'h01, 1'b0, 0, 0, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_op8(8'h05, 8'h05, 1'b1, 1, 0, 8'hFF, 1'b1, 1'b0, 1'b0);
      run_op8(8'h80, 8'h01, 1'b0, 0, 0, 8'h7F, 1'b0, 1'b1, 1'b0);
      run_op8(8'h7F, 8'hFF, 1'b0, 0, 5, 8'h80, 1'b1, 1'b1, 1'b0);
      run_op8(8'h33, 8'h11, 1'b0, 0, 2, 8'h22, 1'b0, 1'b0, 1'b1);
      run_op8(8'hFF, 8'hFF, 1'b1, 0, 0, 8'hFF, 1'b1, 1'b0, 1'b0);

      // Reset during RUN, after the second digit edge.
      a = 8'h44; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("abort_diff", {24'd0, diff}, 32'd0);
      run_op8(8'h10, 8'h20, 1'b1, 0, 0, 8'hEF, 1'b1, 1'b0, 1'b0);

      // Random operations with random handshake gaps, reference A-B-Borrow_in.
      for (int i = 0; i < 300; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rbin = 1'($urandom);
         r    = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
         ed   = r[7:0];
         eo   = (ra[7] ^ rb[7]) & (ed[7] ^ ra[7]);
         run_op8(ra, rb, rbin, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ed, r[8], eo, 1'($urandom));
      end

      // WIDTH=2: all 32 operand combinations.
      n = 0;
      while (!in_ready2 && n < 10) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 32; i++) begin
         run_op2(i[4:3], i[2:1], i[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
